igen_pipe: RTL and testbench

Registered, parametrised successor to the combinational immediate generator. It accepts one RV32I instruction plus its PC per valid/ready handshake and classifies the format. It emits the sign-extended immediate, a format code, an illegal flag and pc+imm one cycle later. It sits between fetch and decode/execute, with an optional skid buffer so backpressure never creates a combinational ready path.

---
 rtl/igen_pkg.sv | 27 ++
 rtl/igen_core.sv | 65 ++++++
 rtl/igen_pipe.sv | 167 ++++++++++++++++
 tb/tb_igen_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/igen_pkg.sv
// Shared definitions for the registered immediate generator:
// RV32I major opcodes and the output format code.
package igen_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // FMT_R doubles as the reset value of the format field, hence code 0.
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

endpackage

// File: rtl/igen_core.sv
// Combinational RV32I immediate decode: insn -> sign-extended imm, format, illegal.
// Optional IGEN_SHAMT_EN: slli/srli/srai yield the 5-bit zero-extended shamt.
module igen_core
    import igen_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [31:0]       insn,
    output logic [DWIDTH-1:0] imm,
    output logic [2:0]        fmt,
    output logic              illegal
);

    logic [31:0] imm32;
    fmt_e        fmt_d;

    // Classify the opcode and assemble the 32-bit immediate for that format.
    always_comb begin
        imm32   = '0;
        fmt_d   = FMT_R;
        illegal = 1'b0;
        case (insn[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt_d = FMT_I;
                imm32 = {{20{insn[31]}}, insn[31:20]};
            end
            OP_STORE: begin
                fmt_d = FMT_S;
                imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            OP_BRANCH: begin
                fmt_d = FMT_B;
                imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_d = FMT_U;
                imm32 = {insn[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_d = FMT_J;
                imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            end
            OP_REG: begin
                fmt_d = FMT_R;
                imm32 = '0;
            end
            default: begin
                fmt_d   = FMT_ILL;
                illegal = 1'b1;
                imm32   = '0;
            end
        endcase
`ifdef IGEN_SHAMT_EN
        // funct3 001/101 is slli/srli/srai; funct7 is kept out of the shift amount.
        if (insn[6:0] == OP_IMM && insn[13:12] == 2'b01) begin
            imm32 = {27'b0, insn[24:20]};
        end
`endif
    end

    // The top immediate bit is bit 31 for every format, so widen from there.
    assign imm = DWIDTH'($signed(imm32));
    assign fmt = fmt_d;

endmodule

// File: rtl/igen_pipe.sv
// Registered immediate generator with valid/ready handshake on both sides.
// Adds pc+imm and holds results in an output register, plus an optional skid
// register (SKID=1) so that in_ready_o never depends combinationally on out_ready_i.
// DWIDTH must be >= 32. Build option: IGEN_SHAMT_EN (see igen_core).
//
// Skid control (SKID=1), state = {out_valid, skid_valid}:
//   state | meaning
//   00    | empty, in_ready_o = 1
//   10    | one result in out regs, in_ready_o = 1
//   11    | full, in_ready_o = 0 until the skid entry drains
module igen_pipe
    import igen_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic [2:0]        fmt_o,
    output logic              illegal_o,
    output logic [AWIDTH-1:0] target_o
);

    // Widths depend on the instance parameters, so the entry type lives here.
    typedef struct packed {
        logic [31:0]       insn;
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] imm;
        logic [2:0]        fmt;
        logic              illegal;
        logic [AWIDTH-1:0] target;
    } igen_res_t;

    localparam igen_res_t RES_RST = '{
        insn: '0, pc: '0, imm: '0, fmt: FMT_R, illegal: 1'b0, target: '0
    };

    logic [DWIDTH-1:0] core_imm;
    logic [2:0]        core_fmt;
    logic              core_illegal;
    igen_res_t         new_res;
    igen_res_t         out_res;
    logic              out_valid;
    logic              in_ready;
    logic              accept;
    logic              pop;

    igen_core #(.DWIDTH(DWIDTH)) u_core (
        .insn    (insn_i),
        .imm     (core_imm),
        .fmt     (core_fmt),
        .illegal (core_illegal)
    );

    // Bundle the decode result with the branch/jump target for this accept.
    always_comb begin
        new_res         = RES_RST;
        new_res.insn    = insn_i;
        new_res.pc      = pc_i;
        new_res.imm     = core_imm;
        new_res.fmt     = core_fmt;
        new_res.illegal = core_illegal;
        new_res.target  = pc_i + AWIDTH'($signed(core_imm));
    end

    assign accept = in_valid_i & in_ready;
    assign pop    = out_valid & out_ready_i;

    if (SKID != 0) begin : g_skid
        igen_res_t skid_res;
        logic      skid_valid;
        logic      ready_q;
        logic      out_valid_n;
        logic      skid_valid_n;
        logic      load_out_new;
        logic      load_out_skid;
        logic      load_skid;

        // Next-state: keep FIFO order by always refilling out regs from skid first.
        always_comb begin
            out_valid_n   = out_valid;
            skid_valid_n  = skid_valid;
            load_out_new  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
            if (pop) begin
                if (skid_valid) begin
                    load_out_skid = 1'b1;
                    out_valid_n   = 1'b1;
                    load_skid     = accept;
                    skid_valid_n  = accept;
                end else begin
                    load_out_new = accept;
                    out_valid_n  = accept;
                end
            end else if (accept) begin
                if (!out_valid) begin
                    load_out_new = 1'b1;
                    out_valid_n  = 1'b1;
                end else begin
                    load_skid    = 1'b1;
                    skid_valid_n = 1'b1;
                end
            end
        end

        // State and data registers; ready tracks the skid slot being free.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
                out_res    <= RES_RST;
                skid_res   <= RES_RST;
            end else begin
                out_valid  <= out_valid_n;
                skid_valid <= skid_valid_n;
                ready_q    <= !skid_valid_n;
                if (load_out_new) begin
                    out_res <= new_res;
                end else if (load_out_skid) begin
                    out_res <= skid_res;
                end
                if (load_skid) begin
                    skid_res <= new_res;
                end
            end
        end

        assign in_ready = ready_q;
    end else begin : g_noskid
        // Single output stage: a new accept overwrites, a bare pop empties.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_valid <= 1'b0;
                out_res   <= RES_RST;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_res   <= new_res;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end

        assign in_ready = !out_valid | out_ready_i;
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid;
    assign insn_o      = out_res.insn;
    assign pc_o        = out_res.pc;
    assign imm_o       = out_res.imm;
    assign fmt_o       = out_res.fmt;
    assign illegal_o   = out_res.illegal;
    assign target_o    = out_res.target;

endmodule

// File: tb/tb_igen_pipe.sv
// Bench for igen_pipe (DWIDTH=AWIDTH=32, SKID=1): directed cases, backpressure,
// reset mid-flight and a random valid/ready run against a queue-based model.
module tb_igen_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] insn_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] insn_o;
    logic [31:0] pc_o;
    logic [31:0] imm_o;
    logic [2:0]  fmt_o;
    logic        illegal_o;
    logic [31:0] target_o;

    igen_pipe #(.DWIDTH(32), .AWIDTH(32), .SKID(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .insn_i      (insn_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .insn_o      (insn_o),
        .pc_o        (pc_o),
        .imm_o       (imm_o),
        .fmt_o       (fmt_o),
        .illegal_o   (illegal_o),
        .target_o    (target_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] target;
    } exp_t;

    exp_t         q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic         hold_pending = 1'b0;
    logic [131:0] held;
    logic         last_ready;
    logic         last_ovalid;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode from the RV32I immediate rules, using plain arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
        exp_t        e;
        logic [31:0] u;
        int          v;
        e.insn = ins;
        e.pc   = p;
        e.ill  = 1'b0;
        e.fmt  = 3'd0;
        v      = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd1;
                v     = $signed(ins) >>> 20;
`ifdef IGEN_SHAMT_EN
                if (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
                    v = int'(ins[24:20]);
`endif
            end
            7'h23: begin
                e.fmt = 3'd2;
                v     = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
            end
            7'h63: begin
                e.fmt = 3'd3;
                u = (32'(ins[31]) << 12) | (32'(ins[7]) << 11) |
                    (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                v = int'(u);
                if (v >= 4096) v = v - 8192;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v     = int'(ins & 32'hFFFFF000);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                u = (32'(ins[31]) << 20) | (32'(ins[19:12]) << 12) |
                    (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
                v = int'(u);
                if (v >= (1 << 20)) v = v - (1 << 21);
            end
            7'h33: e.fmt = 3'd0;
            default: begin
                e.fmt = 3'd7;
                e.ill = 1'b1;
            end
        endcase
        e.imm    = 32'(v);
        e.target = p + 32'(v);
        return e;
    endfunction

    // One clock: drive, sample mid-cycle, score a pop, then record an accept.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, output logic acc);
        logic         pp;
        logic [131:0] cur;
        exp_t         e;
        in_valid_i  = v;
        insn_i      = ins;
        pc_i        = p;
        out_ready_i = ordy;
        #1;
        last_ready  = in_ready_o;
        last_ovalid = out_valid_o;
        acc = v & in_ready_o;
        pp  = out_valid_o & ordy;
        cur = {insn_o, pc_o, imm_o, fmt_o, illegal_o, target_o};
        if (hold_pending) begin
            chk("hold_valid", out_valid_o, 1'b1);
            chk("hold_data", cur, held);
        end
        hold_pending = out_valid_o & !ordy;
        held = cur;
        if (pp) begin
            chk("pop_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("insn", insn_o, e.insn);
                chk("pc", pc_o, e.pc);
                chk("imm", imm_o, e.imm);
                chk("fmt", fmt_o, e.fmt);
                chk("illegal", illegal_o, e.ill);
                chk("target", target_o, e.target);
            end
        end
        @(posedge clk);
        if (acc) q.push_back(model(ins, p));
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] bp_ins[4];
        logic [31:0] ops[12];
        logic [31:0] rins;
        logic [31:0] shamt_exp;
        int          idx;
        int          cyc;

        reset = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; insn_i = '0; pc_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_data", {insn_o, pc_o, imm_o, target_o}, 128'd0);
        chk("rst_fmt", fmt_o, 3'd0);
        chk("rst_illegal", illegal_o, 1'b0);
        @(negedge clk);

        // I-type, one-cycle latency
        step(1'b1, 32'hFFB10093, 32'h100, 1'b1, acc);
        chk("i_latency", out_valid_o, 1'b1);
        chk("i_imm", imm_o, 32'hFFFFFFFB);
        chk("i_fmt", fmt_o, 3'd1);
        chk("i_target", target_o, 32'h000000FB);
        chk("i_illegal", illegal_o, 1'b0);
        step(1'b1, 32'hFE208EE3, 32'h200, 1'b1, acc);
        chk("b_imm", imm_o, 32'hFFFFFFFC);
        chk("b_fmt", fmt_o, 3'd3);
        chk("b_target", target_o, 32'h000001FC);
        step(1'b1, 32'h800000EF, 32'h0, 1'b1, acc);
        chk("j_imm", imm_o, 32'hFFF00000);
        chk("j_target", target_o, 32'hFFF00000);
        step(1'b1, 32'h0000007F, 32'h12345678, 1'b1, acc);
        chk("ill_flag", illegal_o, 1'b1);
        chk("ill_fmt", fmt_o, 3'd7);
        chk("ill_imm", imm_o, 32'h0);
        chk("ill_target", target_o, 32'h12345678);
        step(1'b1, 32'h40515093, 32'h40, 1'b1, acc);
`ifdef IGEN_SHAMT_EN
        shamt_exp = 32'h5;
`else
        shamt_exp = 32'h405;
`endif
        chk("shamt_imm", imm_o, shamt_exp);
        step(1'b0, 32'h0, 32'h0, 1'b1, acc);
        chk("drain_directed", q.size(), 0);

        // Backpressure: four back-to-back, sink stalled for four cycles
        bp_ins[0] = 32'h00500113; bp_ins[1] = 32'h00112223;
        bp_ins[2] = 32'h123450B7; bp_ins[3] = 32'h002081B3;
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 12) begin
            step(1'b1, bp_ins[idx], 32'h1000 + 32'(idx * 4), (cyc >= 4), acc);
            if (cyc < 2)       chk("bp_ready_open", last_ready, 1'b1);
            else if (cyc < 4)  chk("bp_ready_closed", last_ready, 1'b0);
            else               chk("bp_no_gap", last_ovalid, 1'b1);
            if (acc) idx++;
            cyc++;
        end
        chk("bp_all_accepted", idx, 4);
        step(1'b0, 32'h0, 32'h0, 1'b1, acc);
        chk("bp_last_no_gap", last_ovalid, 1'b1);
        chk("bp_drained", q.size(), 0);

        // Reset with both entries occupied; the reset-cycle offer is dropped too
        step(1'b1, 32'h00A00093, 32'h2000, 1'b0, acc);
        step(1'b1, 32'h00B00093, 32'h2004, 1'b0, acc);
        reset = 1'b1; in_valid_i = 1'b1; insn_i = 32'h00C00093; pc_i = 32'h2008;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid_i = 1'b0;
        q.delete();
        hold_pending = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid_o, 1'b0);
        chk("rst_mid_in_ready", in_ready_o, 1'b1);
        chk("rst_mid_imm", imm_o, 32'h0);
        @(negedge clk);
        repeat (3) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, acc);
            chk("rst_no_ghost", last_ovalid, 1'b0);
        end

        // Random traffic against the scoreboard
        ops[0] = 32'h13; ops[1] = 32'h03; ops[2]  = 32'h67; ops[3]  = 32'h73;
        ops[4] = 32'h23; ops[5] = 32'h63; ops[6]  = 32'h37; ops[7]  = 32'h17;
        ops[8] = 32'h6F; ops[9] = 32'h33; ops[10] = 32'h7F; ops[11] = 32'h0B;
        for (int i = 0; i < 400; i++) begin
            rins = $urandom;
            rins[6:0] = ops[$urandom_range(0, 11)][6:0];
            step(($urandom_range(0, 9) < 7), rins, $urandom, ($urandom_range(0, 9) < 6), acc);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, acc);
        end
        chk("rand_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
